// File: rtl/active_list_pkg.sv
// Shared types for the active list (reorder buffer) and its rollback walker.
// Provides the physical register type, the active list tag type, the
// per-entry record and the rollback FSM state encoding.
package active_list_pkg;

  localparam int PHYS_REG_COUNT = 64;
  localparam int LOGICAL_REG_W  = 5;
  localparam int AL_DEPTH       = 32;

  typedef logic [$clog2(PHYS_REG_COUNT)-1:0] phys_reg_t;
  typedef logic [LOGICAL_REG_W-1:0]          logical_reg_t;
  typedef logic [$clog2(AL_DEPTH)-1:0]       al_tag_t;

  typedef struct packed {
    logic         valid;
    logic         done;
    logic         has_dest;
    logical_reg_t logical;
    phys_reg_t    new_phys;
    phys_reg_t    prev_phys;
  } active_list_entry_t;

  typedef enum logic {
    AL_IDLE     = 1'b0,
    AL_ROLLBACK = 1'b1
  } al_state_t;

endpackage

// File: rtl/active_list_rollback_fsm.sv
// Rollback walker for the active list.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// AL_IDLE  | normal operation; allocation/commit allowed
// AL_ROLLBACK | walking squashed entries youngest-first, one per cycle
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   flush_valid  mispredict reported this cycle
//   flush_hit    the flushed tag names a valid entry
//   flush_tag    mispredicted branch tag
//   tail         current tail pointer of the list
//   idle         FSM is in AL_IDLE
//   step         one squashed entry (at walk) is consumed this cycle
//   last         this step is the final one of the walk
//   walk         entry being consumed while step is high
module active_list_rollback_fsm
  import active_list_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_valid,
  input  logic             flush_hit,
  input  logic [TAG_W-1:0] flush_tag,
  input  logic [TAG_W-1:0] tail,
  output logic             idle,
  output logic             step,
  output logic             last,
  output logic [TAG_W-1:0] walk
);

  al_state_t        state, state_n;
  logic [TAG_W-1:0] walk_q, walk_n;
  logic [TAG_W-1:0] stop_q, stop_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= AL_IDLE;
      walk_q <= '0;
      stop_q <= '0;
    end else begin
      state  <= state_n;
      walk_q <= walk_n;
      stop_q <= stop_n;
    end
  end

  always_comb begin
    state_n = state;
    walk_n  = walk_q;
    stop_n  = stop_q;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state)
      AL_IDLE: begin
        // A flush of the youngest entry squashes nothing, so no walk.
        if (flush_valid && flush_hit && (flush_tag != tail - 1'b1)) begin
          state_n = AL_ROLLBACK;
          walk_n  = tail - 1'b1;
          stop_n  = flush_tag + 1'b1;
        end
      end
      AL_ROLLBACK: begin
        step = 1'b1;
        if (walk_q == stop_q) begin
          last    = 1'b1;
          state_n = AL_IDLE;
        end else begin
          walk_n = walk_q - 1'b1;
        end
      end
      default: state_n = AL_IDLE;
    endcase
  end

  assign idle = (state == AL_IDLE);
  assign walk = walk_q;

endmodule

// File: rtl/active_list.sv
// In-order active list (reorder buffer) sitting behind the register map table.
// Allocates one entry per renamed instruction, retires completed entries in
// program order (returning prev_phys to the free list), and on a mispredict
// walks squashed entries youngest-first so map table and free list recover.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   alloc_*                     rename-side allocation handshake and payload
//   alloc_tag                   tag given to the entry allocated this cycle
//   complete_valid/_tag         writeback completion
//   commit_*                    head retirement toward the free list
//   flush_valid/_tag            mispredict; entries younger than the tag die
//   rb_*                        rollback records, youngest first
//   empty, full, count          occupancy
module active_list
  import active_list_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int PHYS_REGS = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic                     alloc_has_dest,
  input  logical_reg_t             alloc_logical_reg,
  input  phys_reg_t                alloc_new_phys,
  input  phys_reg_t                alloc_prev_phys,
  output logic [$clog2(DEPTH)-1:0] alloc_tag,
  input  logic                     complete_valid,
  input  logic [$clog2(DEPTH)-1:0] complete_tag,
  output logic                     commit_valid,
  output logic                     commit_has_dest,
  output logical_reg_t             commit_logical_reg,
  output phys_reg_t                commit_free_phys,
  input  logic                     commit_ready,
  input  logic                     flush_valid,
  input  logic [$clog2(DEPTH)-1:0] flush_tag,
  output logic                     rb_valid,
  output logical_reg_t             rb_logical_reg,
  output phys_reg_t                rb_prev_phys,
  output phys_reg_t                rb_free_phys,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int TAG_W = $clog2(DEPTH);
  localparam logic [TAG_W:0] COUNT_FULL = (TAG_W+1)'(DEPTH);

  if ((PHYS_REGS != PHYS_REG_COUNT) || (DEPTH < 4) || ((1 << TAG_W) != DEPTH)) begin : g_bad_params
    $error("active_list: DEPTH must be a power of two >= 4 and PHYS_REGS must match phys_reg_t");
  end

  active_list_entry_t entries [DEPTH];
  logic [TAG_W-1:0]   head, tail;
  logic [TAG_W:0]     count_q;

  logic             idle, rb_step, rb_done;
  logic [TAG_W-1:0] walk;
  logic             flush_hit, flush_accept;
  logic             alloc_fire, commit_fire;

  assign flush_hit    = entries[flush_tag].valid;
  assign flush_accept = idle && flush_valid && flush_hit;

  active_list_rollback_fsm #(.TAG_W(TAG_W)) u_rollback (
    .clk        (clk),
    .rst        (rst),
    .flush_valid(flush_valid),
    .flush_hit  (flush_hit),
    .flush_tag  (flush_tag),
    .tail       (tail),
    .idle       (idle),
    .step       (rb_step),
    .last       (rb_done),
    .walk       (walk)
  );

  // Registered count only: a full list cannot allocate even if the head
  // retires in the same cycle.
  assign alloc_ready = (count_q < COUNT_FULL) && idle && !flush_valid;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail;

  assign commit_valid = idle && !flush_valid && entries[head].valid && entries[head].done;
  assign commit_fire  = commit_valid && commit_ready;

  assign commit_has_dest    = commit_valid && entries[head].has_dest;
  assign commit_logical_reg = commit_valid ? entries[head].logical   : '0;
  assign commit_free_phys   = commit_valid ? entries[head].prev_phys : '0;

  assign rb_valid       = rb_step && entries[walk].has_dest;
  assign rb_logical_reg = rb_step ? entries[walk].logical   : '0;
  assign rb_prev_phys   = rb_step ? entries[walk].prev_phys : '0;
  assign rb_free_phys   = rb_step ? entries[walk].new_phys  : '0;

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == COUNT_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (complete_valid && !flush_accept && entries[complete_tag].valid)
        entries[complete_tag].done <= 1'b1;
      if (commit_fire) begin
        entries[head].valid <= 1'b0;
        entries[head].done  <= 1'b0;
        head                <= head + 1'b1;
      end
      if (alloc_fire) begin
        entries[tail].valid     <= 1'b1;
        entries[tail].done      <= 1'b0;
        entries[tail].has_dest  <= alloc_has_dest;
        entries[tail].logical   <= alloc_logical_reg;
        entries[tail].new_phys  <= alloc_new_phys;
        entries[tail].prev_phys <= alloc_prev_phys;
        tail                    <= tail + 1'b1;
      end
      // Squash is ordered last so it overrides a same-cycle completion.
      if (rb_step) begin
        entries[walk].valid <= 1'b0;
        entries[walk].done  <= 1'b0;
        tail                <= tail - 1'b1;
      end
      if (rb_step)
        count_q <= count_q - 1'b1;
      else if (alloc_fire && !commit_fire)
        count_q <= count_q + 1'b1;
      else if (commit_fire && !alloc_fire)
        count_q <= count_q - 1'b1;
    end
  end

  a_no_flush_in_rollback: assert property (@(posedge clk) disable iff (rst) !(!idle && flush_valid));
  a_done_returns_idle:    assert property (@(posedge clk) disable iff (rst) rb_done |=> idle);

endmodule

// File: tb/tb_active_list.sv
module tb_active_list;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       alloc_valid, alloc_ready, alloc_has_dest;
  logic [4:0] alloc_logical_reg;
  logic [5:0] alloc_new_phys, alloc_prev_phys;
  logic [4:0] alloc_tag;
  logic       complete_valid;
  logic [4:0] complete_tag;
  logic       commit_valid, commit_has_dest, commit_ready;
  logic [4:0] commit_logical_reg;
  logic [5:0] commit_free_phys;
  logic       flush_valid;
  logic [4:0] flush_tag;
  logic       rb_valid;
  logic [4:0] rb_logical_reg;
  logic [5:0] rb_prev_phys, rb_free_phys;
  logic       empty, full;
  logic [5:0] count;

  always #5 clk = ~clk;

  active_list #(.DEPTH(DEPTH), .PHYS_REGS(64)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_has_dest(alloc_has_dest),
    .alloc_logical_reg(alloc_logical_reg), .alloc_new_phys(alloc_new_phys),
    .alloc_prev_phys(alloc_prev_phys), .alloc_tag(alloc_tag),
    .complete_valid(complete_valid), .complete_tag(complete_tag),
    .commit_valid(commit_valid), .commit_has_dest(commit_has_dest),
    .commit_logical_reg(commit_logical_reg), .commit_free_phys(commit_free_phys),
    .commit_ready(commit_ready),
    .flush_valid(flush_valid), .flush_tag(flush_tag),
    .rb_valid(rb_valid), .rb_logical_reg(rb_logical_reg), .rb_prev_phys(rb_prev_phys),
    .rb_free_phys(rb_free_phys),
    .empty(empty), .full(full), .count(count)
  );

  // Reference model: program-ordered queue of live instructions; the tag of
  // element i is (m_head + i) mod DEPTH.
  typedef struct {
    bit         hd;
    logic [4:0] lr;
    logic [5:0] np;
    logic [5:0] pp;
    bit         done;
  } ent_t;

  ent_t       q[$];
  logic [4:0] m_head;
  int         rb_left;

  logic [4:0] exp_alloc[$];
  ent_t       exp_commit[$];
  ent_t       exp_rb[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [4:0] tag);
    logic [4:0] d;
    d = tag - m_head;
    if (int'(d) < q.size()) return int'(d);
    return -1;
  endfunction

  // Scoreboard monitor: pops an expectation whenever the DUT presents a
  // transfer; an unexpected transfer is itself a failure.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (alloc_valid && alloc_ready) begin
        if (exp_alloc.size() == 0) chk("alloc_unexpected", 1, 0);
        else chk("alloc_tag", 32'(alloc_tag), 32'(exp_alloc.pop_front()));
      end
      if (commit_valid && commit_ready) begin
        if (exp_commit.size() == 0) chk("commit_unexpected", 1, 0);
        else begin
          ent_t e;
          e = exp_commit.pop_front();
          chk("commit_rec", {commit_has_dest, commit_logical_reg, commit_free_phys}, {e.hd, e.lr, e.pp});
        end
      end
      if (rb_valid) begin
        if (exp_rb.size() == 0) chk("rb_unexpected", 1, 0);
        else begin
          ent_t e;
          e = exp_rb.pop_front();
          chk("rb_rec", {rb_logical_reg, rb_prev_phys, rb_free_phys}, {e.lr, e.pp, e.np});
        end
      end
    end
  end

  task automatic clear_inputs();
    alloc_valid = 0; alloc_has_dest = 0; alloc_logical_reg = 0; alloc_new_phys = 0;
    alloc_prev_phys = 0; complete_valid = 0; complete_tag = 0; commit_ready = 0;
    flush_valid = 0; flush_tag = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    @(posedge clk); #1;
    rst = 0;
    q.delete(); m_head = 0; rb_left = 0;
    exp_alloc.delete(); exp_commit.delete(); exp_rb.delete();
  endtask

  task automatic check_reset_outputs();
    chk("rst_empty", empty, 1);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_rb_valid", rb_valid, 0);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_rb_data", {rb_logical_reg, rb_prev_phys, rb_free_phys}, 0);
    chk("rst_commit_data", {commit_has_dest, commit_logical_reg, commit_free_phys}, 0);
  endtask

  task automatic step(input bit av, input bit hd, input logic [4:0] lr, input logic [5:0] np,
                      input logic [5:0] pp, input bit cv, input logic [4:0] ctag, input bit cr,
                      input bit fv, input logic [4:0] ftag);
    bit a_rdy, c_val, f_acc, r_step, a_fire, c_fire, r_vld;
    int fidx, cidx;
    ent_t e;
    alloc_valid = av; alloc_has_dest = hd; alloc_logical_reg = lr;
    alloc_new_phys = np; alloc_prev_phys = pp;
    complete_valid = cv; complete_tag = ctag; commit_ready = cr;
    flush_valid = fv; flush_tag = ftag;

    r_step = (rb_left > 0);
    a_rdy  = (q.size() < DEPTH) && !r_step && !fv;
    c_val  = !r_step && !fv && (q.size() > 0) && q[0].done;
    fidx   = idx_of(ftag);
    f_acc  = fv && !r_step && (fidx >= 0);
    a_fire = av && a_rdy;
    c_fire = c_val && cr;
    r_vld  = r_step && q[q.size()-1].hd;
    if (a_fire) exp_alloc.push_back(5'(m_head + 5'(q.size())));
    if (c_fire) exp_commit.push_back(q[0]);

    @(negedge clk);
    chk("alloc_ready", alloc_ready, a_rdy);
    chk("commit_valid", commit_valid, c_val);
    chk("rb_valid", rb_valid, r_vld);

    @(posedge clk); #1;
    cidx = idx_of(ctag);
    if (cv && !f_acc && cidx >= 0 && !(r_step && cidx == q.size() - 1)) q[cidx].done = 1;
    if (c_fire) begin
      void'(q.pop_front());
      m_head = m_head + 5'd1;
    end
    if (a_fire) begin
      e.hd = hd; e.lr = lr; e.np = np; e.pp = pp; e.done = 0;
      q.push_back(e);
    end
    if (r_step) begin
      void'(q.pop_back());
      rb_left--;
    end
    if (f_acc && fidx != q.size() - 1) begin
      rb_left = q.size() - 1 - fidx;
      for (int i = q.size() - 1; i > fidx; i--)
        if (q[i].hd) exp_rb.push_back(q[i]);
    end
    chk("count", 32'(count), 32'(q.size()));
    chk("empty", empty, q.size() == 0);
    chk("full", full, q.size() == DEPTH);
  endtask

  task automatic alloc1(input bit hd, input logic [4:0] lr, input logic [5:0] np, input logic [5:0] pp);
    step(1, hd, lr, np, pp, 0, 0, 0, 0, 0);
  endtask

  task automatic idle_cyc(input int n, input bit cr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, cr, 0, 0);
  endtask

  task automatic complete1(input logic [4:0] tag, input bit cr);
    step(0, 0, 0, 0, 0, 1, tag, cr, 0, 0);
  endtask

  task automatic flush1(input logic [4:0] tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1;
    clear_inputs();
    m_head = 0; rb_left = 0;

    // Reset, then three allocations and out-of-order completion.
    do_reset();
    check_reset_outputs();
    for (int i = 1; i <= 3; i++) alloc1(1, 5'(i), 6'(31 + i), 6'(i));
    chk("three_alloc_count", count, 3);
    complete1(1, 1);
    complete1(0, 1);
    idle_cyc(4, 1);
    chk("tag2_pending_count", count, 1);
    complete1(2, 1);
    idle_cyc(2, 1);

    // Fill the list, then commit while allocation is held off by full.
    do_reset();
    for (int i = 0; i < DEPTH; i++) alloc1(1, 5'(i), 6'(i + 20), 6'(i));
    chk("full_flag", full, 1);
    chk("full_alloc_ready", alloc_ready, 0);
    step(1, 1, 5'd7, 6'd50, 6'd7, 1, 5'd0, 1, 0, 0);
    step(1, 1, 5'd7, 6'd50, 6'd7, 0, 5'd0, 1, 0, 0);
    chk("full_after_commit_count", count, DEPTH - 1);
    step(1, 1, 5'd7, 6'd50, 6'd7, 0, 5'd0, 0, 0, 0);
    chk("wrap_full_again", full, 1);

    // Five entries, tag2 without a destination, flush tag1.
    do_reset();
    for (int i = 0; i < 5; i++) alloc1(i != 2, 5'(i + 10), 6'(i + 40), 6'(i + 1));
    flush1(1);
    idle_cyc(3, 0);
    chk("rollback_count", count, 2);
    chk("rollback_tag", alloc_tag, 2);
    chk("rollback_ready", alloc_ready, 1);
    alloc1(1, 5'd20, 6'd60, 6'd21);

    // Flush of the youngest entry: no walk, allocation resumes at once.
    flush1(2);
    alloc1(1, 5'd21, 6'd61, 6'd22);
    chk("youngest_flush_count", count, 4);

    // Reset in the middle of a rollback.
    do_reset();
    for (int i = 0; i < 5; i++) alloc1(1, 5'(i), 6'(i + 32), 6'(i));
    flush1(0);
    idle_cyc(1, 0);
    do_reset();
    chk("midrb_empty", empty, 1);
    chk("midrb_rb_valid", rb_valid, 0);
    chk("midrb_alloc_ready", alloc_ready, 1);
    complete1(3, 1);
    idle_cyc(2, 1);

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit         av, hd, cv, cr, fv;
      logic [4:0] lr, ctag, ftag;
      logic [5:0] np, pp;
      av = ($urandom_range(0, 99) < 60);
      hd = $urandom_range(0, 1) == 1;
      lr = 5'($urandom); np = 6'($urandom); pp = 6'($urandom);
      cv = ($urandom_range(0, 99) < 50);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        ctag = 5'(m_head + 5'($urandom_range(0, q.size() - 1)));
      else
        ctag = 5'($urandom);
      cr = ($urandom_range(0, 99) < 70);
      fv = 0;
      ftag = 5'($urandom);
      if (rb_left == 0 && q.size() > 0 && $urandom_range(0, 99) < 4) begin
        fv = 1;
        ftag = 5'(m_head + 5'($urandom_range(0, q.size() - 1)));
      end
      step(av, hd, lr, np, pp, cv, ctag, cr, fv, ftag);
    end
    idle_cyc(40, 1);

    chk("leftover_alloc", exp_alloc.size(), 0);
    chk("leftover_commit", exp_commit.size(), 0);
    chk("leftover_rb", exp_rb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/active_list.md
Name: active_list

Overview:
- In-order active list (reorder buffer) directly downstream of the register map table.
- Each renamed instruction allocates one entry at rename. The entry holds the logical destination, the newly assigned physical register, and the previous physical mapping supplied by the map table.
- Entries retire in program order once complete, returning the previous physical register to the free list.
- On a branch mispredict, squashed entries are walked youngest-first so the map table and free list can be restored.

Parameters:
DEPTH, 32, number of entries; power of two, >=4
PHYS_REGS, 64, physical register count; sets phys_reg_t width (6 bits)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alloc_valid  in  1  rename stage presents an instruction
alloc_ready  out  1  entry available and not rolling back
alloc_has_dest  in  1  instruction writes a register (uses_rw)
alloc_logical_reg  in  5  logical destination (rw_addr before rename)
alloc_new_phys  in  6  physical register assigned by renaming
alloc_prev_phys  in  6  prev_physical_reg from the map table
alloc_tag  out  log2(DEPTH)  index given to the allocated entry (= tail)
complete_valid  in  1  writeback reports completion
complete_tag  in  log2(DEPTH)  entry being completed
commit_valid  out  1  head entry retiring this cycle
commit_has_dest  out  1  head had a destination
commit_logical_reg  out  5  retiring logical register
commit_free_phys  out  6  prev_phys to return to the free list
commit_ready  in  1  free list accepts the return
flush_valid  in  1  mispredict detected
flush_tag  in  log2(DEPTH)  mispredicted branch; all younger entries squashed
rb_valid  out  1  rollback record valid
rb_logical_reg  out  5  map-table entry to restore
rb_prev_phys  out  6  value to restore into the map table
rb_free_phys  out  6  squashed new_phys returned to the free list
empty  out  1  count==0
full  out  1  count==DEPTH
count  out  log2(DEPTH)+1  occupied entries

Behaviour:
- State: head, tail pointers (log2 DEPTH bits, wrap modulo DEPTH), count register, per-entry valid/done/has_dest/logical/new_phys/prev_phys.
- FSM states:
  - IDLE: normal operation.
  - ROLLBACK: walking squashed entries.
- Reset: head=tail=count=0, all valid/done cleared, state=IDLE. All outputs 0 except empty=1 and alloc_ready=1 on the cycle after reset.
- alloc_ready = (count<DEPTH) && state==IDLE && !flush_valid. It is based on registered count, so a full list never allocates, even when a commit occurs the same cycle.
- Allocation fires on alloc_valid&&alloc_ready:
  - entry[tail] written with valid=1, done=0;
  - tail increments at the clock edge;
  - alloc_tag equals the pre-increment tail, combinationally.
- Completion: complete_valid sets done on the next edge only if entry[complete_tag].valid. Completion of an invalid or squashed entry is ignored.
- Commit:
  - commit_valid = state==IDLE && !flush_valid && entry[head].valid && entry[head].done, using registered done only. A completion and a commit of the same head entry take 2 cycles minimum.
  - Commit fires on commit_valid&&commit_ready: entry invalidated, head++.
  - commit_free_phys = prev_phys; commit_has_dest is 0 for no-destination entries, and the free list ignores those.
- Simultaneous alloc and commit: count unchanged; both pointers advance.
- Flush:
  - Accepted only in IDLE with flush_valid and entry[flush_tag].valid. In the flush cycle, no alloc, commit or complete takes effect.
  - If flush_tag==tail-1 (no younger entries): remain IDLE.
  - Otherwise: enter ROLLBACK with walk pointer = tail-1.
- ROLLBACK:
  - One record per cycle, youngest first.
  - rb_valid=1 for entries with has_dest; entries without a destination are still consumed one per cycle with rb_valid=0.
  - Each step invalidates the entry and decrements tail and count.
  - Exit to IDLE on the cycle the walk pointer reaches flush_tag+1 (that entry processed). alloc_ready returns the following cycle.
- flush_valid during ROLLBACK: ignored (assertion). complete_valid during ROLLBACK: honoured for surviving entries only.
- Reset mid-rollback: returns to IDLE empty. The map table and free list are reset by their own rst.

Decomposition:
- mips_core_pkg gains:
  - phys_reg_t (logic [5:0]);
  - PHYS_REG_COUNT=64;
  - active_list_entry_t struct (valid, done, has_dest, logical, new_phys, prev_phys);
  - al_tag_t.
- One sub-module, active_list_rollback_fsm: owns the state and the walk pointer, and emits the step/done strobes.
- The entry storage stays in active_list.
- The input side reuses register_Map_Table_Pairing_ifc.in for prev_physical_reg/prev_logical_reg.

Test Plan:
- Reset, then allocate 3 entries (logical 1,2,3; new_phys 32,33,34; prev 1,2,3) -> alloc_tag 0,1,2; count=3.
- Complete tags 1 then 0; commit_ready=1 -> commits tag0 (free_phys=1) then tag1 (free_phys=2) in order; tag2 does not commit until completed.
- Allocate 32 with no completion -> full=1, alloc_ready=0. Complete head and commit while alloc_valid held -> no alloc that cycle; alloc succeeds the next cycle at tag 0 (wrap).
- Allocate 5 (tags 0-4, tag2 without a destination), then flush_tag=1 -> rb records in cycles 1..3:
  - tag4: rb_valid=1, logical/prev/new restored;
  - tag3: rb_valid=1;
  - tag2: rb_valid=0;
  - then IDLE; count=2, next alloc_tag=2.
- flush_tag == youngest tag -> no rollback; alloc_ready resumes the next cycle.
- Assert rst during ROLLBACK -> next cycle empty=1, rb_valid=0, state IDLE. complete_valid to the squashed tag afterwards -> no effect.
